hilo_mult_unit: RTL and testbench

- Multi-cycle multiply / HI-LO unit in the EX stage, directly downstream of the ALU control decoder.
- Consumes ALUOp = 4'b1111 (multiply class) together with Opcode/Funct and executes mult, multu, mul, madd and msub with an iterative shift-add core.
- Also serves mthi, mtlo, mfhi and mflo.
- Owns the architectural HI/LO registers and raises Busy so the hazard unit can stall the pipeline.

---
 rtl/hilo_pkg.sv | 20 ++
 rtl/hilo_mult_unit_if.sv | 28 ++
 rtl/hilo_mult_unit_shift_add_core.sv | 41 ++++
 rtl/hilo_mult_unit.sv | 168 ++++++++++++++++
 tb/tb_hilo_mult_unit.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared encodings and enums for the multiply / HI-LO unit.
package hilo_pkg;
    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MUL   = 6'b000010;
    localparam logic [5:0] FN_MADD  = 6'b000000;
    localparam logic [5:0] FN_MSUB  = 6'b000100;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    localparam logic [3:0] ALUOP_MUL = 4'b1111;

    typedef enum logic [1:0] {IDLE, MULT, FIN} state_e;
    typedef enum logic [2:0] {K_MULT, K_MULTU, K_MUL, K_MADD, K_MSUB} op_kind_e;
endpackage

// File: rtl/hilo_mult_unit_if.sv
// EX-stage request / HI-LO result bundle for the multiply unit.
interface hilo_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             Valid;
    logic [3:0]       ALUOp;
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Flush;
    logic             Busy;
    logic             Stall;
    logic             Done;
    logic [WIDTH-1:0] MulResult;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Valid, ALUOp, Opcode, Funct, A, B, Flush,
        input  Busy, Stall, Done, MulResult, HI, LO
    );

    modport slave (
        input  Valid, ALUOp, Opcode, Funct, A, B, Flush,
        output Busy, Stall, Done, MulResult, HI, LO
    );
endinterface

// File: rtl/hilo_mult_unit_shift_add_core.sv
// Unsigned radix-2 shift-add multiplier: one partial product per i_step.
module shift_add_core #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_step,
    input  logic               i_clear,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_product
);
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_clear) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_product = r_acc;
endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle multiply / HI-LO unit: decode, FSM, sign fix-up, accumulate and
// the architectural HI/LO registers around an unsigned shift-add core.
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic             Clk,
    input logic             Rst_n,
    hilo_mult_unit_if.slave bus
);
    state_e             r_state;
    state_e             w_next;
    op_kind_e           r_kind;
    op_kind_e           w_kind;
    logic               r_neg;
    logic               w_neg;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mulres;
    logic               r_done;

    logic w_sp, w_sp2;
    logic w_dec_mult, w_dec_multu, w_dec_mul, w_dec_madd, w_dec_msub;
    logic w_dec_mthi, w_dec_mtlo, w_dec_mfhi, w_dec_mflo;
    logic w_dec_mul_class, w_dec_any, w_accept;
    logic w_start, w_step, w_clear, w_commit;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_hilo;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    assign w_sp  = (bus.Opcode == OP_SPECIAL);
    assign w_sp2 = (bus.Opcode == OP_SPECIAL2);

    assign w_dec_mult  = w_sp  && (bus.Funct == FN_MULT)  && (bus.ALUOp == ALUOP_MUL);
    assign w_dec_multu = w_sp  && (bus.Funct == FN_MULTU) && (bus.ALUOp == ALUOP_MUL);
    assign w_dec_mul   = w_sp2 && (bus.Funct == FN_MUL);
    assign w_dec_madd  = w_sp2 && (bus.Funct == FN_MADD);
    assign w_dec_msub  = w_sp2 && (bus.Funct == FN_MSUB);
    assign w_dec_mthi  = w_sp  && (bus.Funct == FN_MTHI);
    assign w_dec_mtlo  = w_sp  && (bus.Funct == FN_MTLO);
    assign w_dec_mfhi  = w_sp  && (bus.Funct == FN_MFHI);
    assign w_dec_mflo  = w_sp  && (bus.Funct == FN_MFLO);

    assign w_dec_mul_class = w_dec_mult | w_dec_multu | w_dec_mul | w_dec_madd | w_dec_msub;
    assign w_dec_any       = w_dec_mul_class | w_dec_mthi | w_dec_mtlo | w_dec_mfhi | w_dec_mflo;
    assign w_accept        = (r_state == IDLE) && bus.Valid && !bus.Flush;

    always_comb begin
        w_kind = K_MULT;
        if (w_dec_multu)     w_kind = K_MULTU;
        else if (w_dec_mul)  w_kind = K_MUL;
        else if (w_dec_madd) w_kind = K_MADD;
        else if (w_dec_msub) w_kind = K_MSUB;
    end

    // The core only ever sees magnitudes; the sign is re-applied at FIN.
    assign w_neg   = (w_kind != K_MULTU) && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
    assign w_mag_a = magnitude(bus.A, w_kind != K_MULTU);
    assign w_mag_b = magnitude(bus.B, w_kind != K_MULTU);

    shift_add_core #(.WIDTH(WIDTH)) u_core (
        .i_clk     (Clk),
        .i_rst_n   (Rst_n),
        .i_start   (w_start),
        .i_step    (w_step),
        .i_clear   (w_clear),
        .i_a       (w_mag_a),
        .i_b       (w_mag_b),
        .o_product (w_prod_u)
    );

    assign w_prod = r_neg ? -w_prod_u : w_prod_u;
    assign w_hilo = {r_hi, r_lo};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_step   = 1'b0;
        w_clear  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_dec_mul_class) begin
                    w_next  = MULT;
                    w_start = 1'b1;
                end
            end
            MULT: begin
                if (bus.Flush) begin
                    w_next  = IDLE;
                    w_clear = 1'b1;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_next = FIN;
                    end
                end
            end
            FIN: begin
                w_next = IDLE;
                if (bus.Flush) begin
                    w_clear = 1'b1;
                end else begin
                    w_commit = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt    <= '0;
            r_kind   <= K_MULT;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mulres <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_start) begin
                r_cnt  <= '0;
                r_kind <= w_kind;
                r_neg  <= w_neg;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Moves only happen from IDLE, so they never collide with a commit.
            if (w_commit) begin
                case (r_kind)
                    K_MUL:   r_mulres     <= w_prod[WIDTH-1:0];
                    K_MADD:  {r_hi, r_lo} <= w_hilo + w_prod;
                    K_MSUB:  {r_hi, r_lo} <= w_hilo - w_prod;
                    default: {r_hi, r_lo} <= w_prod;
                endcase
            end else if (w_accept) begin
                if (w_dec_mthi) r_hi <= bus.A;
                if (w_dec_mtlo) r_lo <= bus.A;
            end
        end
    end

    assign bus.Busy      = (r_state != IDLE);
    assign bus.Stall     = (r_state != IDLE) && bus.Valid && w_dec_any;
    assign bus.Done      = r_done;
    assign bus.MulResult = r_mulres;
    assign bus.HI        = r_hi;
    assign bus.LO        = r_lo;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit against a 64-bit arithmetic model.
module tb_hilo_mult_unit;
    import hilo_pkg::*;

    localparam int W = 32;
    localparam int T_MULT = 0, T_MULTU = 1, T_MUL = 2, T_MADD = 3, T_MSUB = 4,
                   T_MTHI = 5, T_MTLO = 6, T_MFHI = 7, T_MFLO = 8;

    logic Clk;
    logic Rst_n;
    int   n_checks;
    int   n_fail;
    logic [W-1:0] m_hi, m_lo, m_mulres;

    hilo_mult_unit_if #(.WIDTH(W)) bus ();

    hilo_mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic set_instr(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Opcode = OP_SPECIAL;
        bus.ALUOp  = 4'b0000;
        case (op)
            T_MULT:  begin bus.Funct = FN_MULT;  bus.ALUOp = ALUOP_MUL; end
            T_MULTU: begin bus.Funct = FN_MULTU; bus.ALUOp = ALUOP_MUL; end
            T_MUL:   begin bus.Opcode = OP_SPECIAL2; bus.Funct = FN_MUL;  bus.ALUOp = ALUOP_MUL; end
            T_MADD:  begin bus.Opcode = OP_SPECIAL2; bus.Funct = FN_MADD; bus.ALUOp = ALUOP_MUL; end
            T_MSUB:  begin bus.Opcode = OP_SPECIAL2; bus.Funct = FN_MSUB; bus.ALUOp = ALUOP_MUL; end
            T_MTHI:  bus.Funct = FN_MTHI;
            T_MTLO:  bus.Funct = FN_MTLO;
            T_MFHI:  bus.Funct = FN_MFHI;
            default: bus.Funct = FN_MFLO;
        endcase
        bus.A     = a;
        bus.B     = b;
        bus.Valid = 1'b1;
    endtask

    // Reference model: plain 64-bit products, no iteration.
    task automatic model_apply(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint     sp;
        logic [63:0] up;
        logic [63:0] acc;
        sp  = longint'($signed(a)) * longint'($signed(b));
        up  = {32'b0, a} * {32'b0, b};
        acc = {m_hi, m_lo};
        case (op)
            T_MULT:  {m_hi, m_lo} = sp;
            T_MULTU: {m_hi, m_lo} = up;
            T_MUL:   m_mulres = sp[31:0];
            T_MADD:  {m_hi, m_lo} = acc + sp;
            T_MSUB:  {m_hi, m_lo} = acc - sp;
            T_MTHI:  m_hi = a;
            T_MTLO:  m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_mul(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int ndone, output int nbusy);
        set_instr(op, a, b);
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
        lat = -1; ndone = 0; nbusy = 0;
        for (int k = 1; k <= 36; k++) begin
            if (bus.Busy) nbusy++;
            @(posedge Clk); #1;
            if (bus.Done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic run_move(input int op, input logic [W-1:0] a);
        set_instr(op, a, '0);
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        bus.Valid = 0; bus.Flush = 0; bus.ALUOp = 0; bus.Opcode = 0; bus.Funct = 0;
        bus.A = 0; bus.B = 0;
        m_hi = 0; m_lo = 0; m_mulres = 0;
        #12;
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: Busy=%b Done=%b required 0 0", bus.Busy, bus.Done);
        end
        n_checks++;
        if ({bus.HI, bus.LO, bus.MulResult} !== 96'h0) begin
            n_fail++; $display("FAIL reset_regs: HI=%h LO=%h MulResult=%h required zeros", bus.HI, bus.LO, bus.MulResult);
        end
        @(negedge Clk); Rst_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_mult();
        int lat, nd, nb;
        run_mul(T_MULT, 32'hFFFFFFFD, 32'd5, lat, nd, nb);
        model_apply(T_MULT, 32'hFFFFFFFD, 32'd5);
        n_checks++;
        if (lat !== 33 || nd !== 1 || nb !== 33) begin
            n_fail++; $display("FAIL mult_timing: lat=%0d dones=%0d busy=%0d required 33 1 33", lat, nd, nb);
        end
        n_checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFF1) begin
            n_fail++; $display("FAIL mult_result: HI=%h LO=%h required ffffffff fffffff1", bus.HI, bus.LO);
        end
    endtask

    task automatic test_multu_mul();
        int lat, nd, nb;
        run_mul(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nd, nb);
        model_apply(T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_checks++;
        if (bus.HI !== 32'hFFFFFFFE || bus.LO !== 32'h00000001) begin
            n_fail++; $display("FAIL multu_result: HI=%h LO=%h required fffffffe 00000001", bus.HI, bus.LO);
        end
        run_mul(T_MUL, 32'd7, 32'hFFFFFFFE, lat, nd, nb);
        model_apply(T_MUL, 32'd7, 32'hFFFFFFFE);
        n_checks++;
        if (bus.MulResult !== 32'hFFFFFFF2 || nd !== 1) begin
            n_fail++; $display("FAIL mul_result: MulResult=%h dones=%0d required fffffff2 1", bus.MulResult, nd);
        end
        n_checks++;
        if (bus.HI !== m_hi || bus.LO !== m_lo) begin
            n_fail++; $display("FAIL mul_hilo_kept: HI=%h LO=%h required %h %h", bus.HI, bus.LO, m_hi, m_lo);
        end
    endtask

    task automatic test_madd_msub();
        int lat, nd, nb;
        run_move(T_MTHI, 32'd0);  model_apply(T_MTHI, 32'd0, 0);
        run_move(T_MTLO, 32'd10); model_apply(T_MTLO, 32'd10, 0);
        n_checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd10 || bus.Done !== 1'b0) begin
            n_fail++; $display("FAIL moves: HI=%h LO=%h Done=%b required 0 a 0", bus.HI, bus.LO, bus.Done);
        end
        run_mul(T_MADD, 32'd3, 32'd4, lat, nd, nb);
        model_apply(T_MADD, 32'd3, 32'd4);
        n_checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd22) begin
            n_fail++; $display("FAIL madd: HI=%h LO=%h required 0 16", bus.HI, bus.LO);
        end
        run_mul(T_MSUB, 32'd5, 32'd5, lat, nd, nb);
        model_apply(T_MSUB, 32'd5, 32'd5);
        n_checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL msub: HI=%h LO=%h required ffffffff fffffffd", bus.HI, bus.LO);
        end
    endtask

    task automatic test_signed_corner();
        int lat, nd, nb;
        run_mul(T_MULT, 32'h80000000, 32'h80000000, lat, nd, nb);
        model_apply(T_MULT, 32'h80000000, 32'h80000000);
        n_checks++;
        if (bus.HI !== 32'h40000000 || bus.LO !== 32'h0) begin
            n_fail++; $display("FAIL signed_corner: HI=%h LO=%h required 40000000 0", bus.HI, bus.LO);
        end
    endtask

    task automatic test_random();
        int lat, nd, nb, op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 14; i++) begin
            op = $urandom_range(0, 6);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h80000000;
            if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF;
            if (op <= T_MSUB) begin
                run_mul(op, a, b, lat, nd, nb);
                n_checks++;
                if (nd !== 1 || lat !== 33) begin
                    n_fail++; $display("FAIL rand_done[%0d]: dones=%0d lat=%0d required 1 33", i, nd, lat);
                end
            end else begin
                run_move(op, a);
            end
            model_apply(op, a, b);
            n_checks++;
            if (bus.HI !== m_hi || bus.LO !== m_lo || bus.MulResult !== m_mulres) begin
                n_fail++;
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: HI=%h LO=%h MR=%h required %h %h %h",
                         i, op, a, b, bus.HI, bus.LO, bus.MulResult, m_hi, m_lo, m_mulres);
            end
        end
    endtask

    task automatic test_stall();
        int waited;
        set_instr(T_MULTU, 32'd6, 32'd7);
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
        repeat (3) begin @(posedge Clk); #1; end
        set_instr(T_MFHI, 32'h0, 32'h0);
        #1;
        n_checks++;
        if (bus.Stall !== 1'b1) begin
            n_fail++; $display("FAIL stall_mfhi: Stall=%b required 1", bus.Stall);
        end
        @(posedge Clk); #1;
        set_instr(T_MTLO, 32'h00001234, 32'h0);
        #1;
        n_checks++;
        if (bus.Stall !== 1'b1) begin
            n_fail++; $display("FAIL stall_mtlo: Stall=%b required 1", bus.Stall);
        end
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
        n_checks++;
        if (bus.LO !== m_lo || bus.HI !== m_hi || bus.Busy !== 1'b1) begin
            n_fail++; $display("FAIL stall_nochange: HI=%h LO=%h Busy=%b required %h %h 1", bus.HI, bus.LO, bus.Busy, m_hi, m_lo);
        end
        waited = 0;
        while (bus.Busy && waited < 40) begin @(posedge Clk); #1; waited++; end
        model_apply(T_MULTU, 32'd6, 32'd7);
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.HI !== m_hi || bus.LO !== m_lo) begin
            n_fail++; $display("FAIL stall_finish: Busy=%b HI=%h LO=%h required 0 %h %h", bus.Busy, bus.HI, bus.LO, m_hi, m_lo);
        end
        set_instr(T_MFLO, 32'h0, 32'h0);
        #1;
        n_checks++;
        if (bus.Stall !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle: Stall=%b required 0", bus.Stall);
        end
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
    endtask

    task automatic test_flush();
        int nd;
        set_instr(T_MULT, 32'h12345678, 32'h9ABCDEF0);
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
        repeat (9) begin @(posedge Clk); #1; end
        bus.Flush = 1'b1;
        @(posedge Clk); #1;
        bus.Flush = 1'b0;
        n_checks++;
        if (bus.Busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: Busy=%b required 0", bus.Busy);
        end
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge Clk); #1;
            if (bus.Done) nd++;
        end
        n_checks++;
        if (nd !== 0 || bus.HI !== m_hi || bus.LO !== m_lo) begin
            n_fail++; $display("FAIL flush_nocommit: dones=%0d HI=%h LO=%h required 0 %h %h", nd, bus.HI, bus.LO, m_hi, m_lo);
        end
        set_instr(T_MULT, 32'd2, 32'd3);
        bus.Flush = 1'b1;
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
        bus.Flush = 1'b0;
        n_checks++;
        if (bus.Busy !== 1'b0) begin
            n_fail++; $display("FAIL flush_blocks_accept: Busy=%b required 0", bus.Busy);
        end
    endtask

    task automatic test_async_reset();
        set_instr(T_MULT, 32'd11, 32'd13);
        @(posedge Clk); #1;
        bus.Valid = 1'b0;
        repeat (5) begin @(posedge Clk); #1; end
        #2;
        Rst_n = 1'b0;
        #1;
        m_hi = 0; m_lo = 0; m_mulres = 0;
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: Busy=%b Done=%b HI=%h LO=%h required 0 0 0 0", bus.Busy, bus.Done, bus.HI, bus.LO);
        end
        @(negedge Clk); Rst_n = 1'b1;
        @(posedge Clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mult();
        test_multu_mul();
        test_madd_msub();
        test_signed_corner();
        test_stall();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
